// File: rtl/tow_playfield.sv
// tow_playfield: tug-of-war light playfield with round scoring and match end.
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous, active-low reset
//   l_press    - one-cycle pulse for each left-player press (pulls the light left)
//   r_press    - one-cycle pulse for each right-player press (pulls the light right)
//   leds       - one-hot light position, MSB leftmost; all zero once the match is over
//   winner     - round winner: 00 none, 01 left, 10 right
//   l_score    - left round-win count
//   r_score    - right round-win count
//   match_over - high once either score has reached WIN_LIMIT
module tow_playfield #(
  parameter int unsigned N_LIGHTS    = 9,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned WIN_LIMIT   = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                l_press,
  input  logic                r_press,
  output logic [N_LIGHTS-1:0] leds,
  output logic [1:0]          winner,
  output logic [2:0]          l_score,
  output logic [2:0]          r_score,
  output logic                match_over
);

  localparam int unsigned POS_W = $clog2(N_LIGHTS);
  localparam int unsigned CNT_W = 8;

  localparam logic [POS_W-1:0]    POS_CENTRE  = POS_W'((N_LIGHTS - 1) / 2);
  localparam logic [POS_W-1:0]    POS_MAX     = POS_W'(N_LIGHTS - 1);
  localparam logic [CNT_W-1:0]    HOLD_LOAD   = CNT_W'(HOLD_CYCLES);
  localparam logic [2:0]          SCORE_MAX   = 3'(WIN_LIMIT);
  localparam logic [1:0]          WIN_NONE    = 2'b00;
  localparam logic [1:0]          WIN_LEFT    = 2'b01;
  localparam logic [1:0]          WIN_RIGHT   = 2'b10;
  localparam logic [N_LIGHTS-1:0] LEDS_CENTRE = N_LIGHTS'(1) << POS_CENTRE;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HOLD = 2'd1,
    ST_IDLE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            winner_q, winner_d;
  logic [2:0]            l_score_q, l_score_d;
  logic [2:0]            r_score_q, r_score_d;
  logic                  match_over_q, match_over_d;
  logic [N_LIGHTS-1:0]   leds_q, leds_d;

  logic l_only, r_only;

  // Simultaneous presses cancel, so only a lone press moves the light.
  assign l_only = l_press & ~r_press;
  assign r_only = r_press & ~l_press;

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    cnt_d        = cnt_q;
    winner_d     = winner_q;
    l_score_d    = l_score_q;
    r_score_d    = r_score_q;
    match_over_d = match_over_q;

    unique case (state_q)
      ST_PLAY: begin
        if (l_only) begin
          if (pos_q == POS_MAX) begin
            // Pulling past the left end wins the round; the light stays put.
            winner_d  = WIN_LEFT;
            l_score_d = (l_score_q == SCORE_MAX) ? l_score_q : l_score_q + 3'd1;
            cnt_d     = HOLD_LOAD;
            state_d   = ST_HOLD;
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end else if (r_only) begin
          if (pos_q == '0) begin
            winner_d  = WIN_RIGHT;
            r_score_d = (r_score_q == SCORE_MAX) ? r_score_q : r_score_q + 3'd1;
            cnt_d     = HOLD_LOAD;
            state_d   = ST_HOLD;
          end else begin
            pos_d = pos_q - POS_W'(1);
          end
        end
      end

      ST_HOLD: begin
        // Counter value 1 marks the last held cycle; presses here are dropped.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d = '0;
          if ((l_score_q == SCORE_MAX) || (r_score_q == SCORE_MAX)) begin
            state_d      = ST_IDLE;
            match_over_d = 1'b1;
          end else begin
            state_d  = ST_PLAY;
            winner_d = WIN_NONE;
            pos_d    = POS_CENTRE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_IDLE: begin
      end

      default: begin
        state_d = ST_PLAY;
        pos_d   = POS_CENTRE;
      end
    endcase

    leds_d = (state_d == ST_IDLE) ? '0 : (N_LIGHTS'(1) << pos_d);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_PLAY;
      pos_q        <= POS_CENTRE;
      cnt_q        <= '0;
      winner_q     <= WIN_NONE;
      l_score_q    <= '0;
      r_score_q    <= '0;
      match_over_q <= 1'b0;
      leds_q       <= LEDS_CENTRE;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      cnt_q        <= cnt_d;
      winner_q     <= winner_d;
      l_score_q    <= l_score_d;
      r_score_q    <= r_score_d;
      match_over_q <= match_over_d;
      leds_q       <= leds_d;
    end
  end

  assign leds       = leds_q;
  assign winner     = winner_q;
  assign l_score    = l_score_q;
  assign r_score    = r_score_q;
  assign match_over = match_over_q;

endmodule

// File: tb/tb_tow_playfield.sv
// Testbench for tow_playfield: table-driven vectors plus a cycle scoreboard
// fed by an independent behavioural model of the game.
module tb_tow_playfield;

  localparam int unsigned N  = 9;
  localparam int unsigned HC = 8;
  localparam int unsigned WL = 7;

  logic         clk     = 1'b0;
  logic         reset   = 1'b1;
  logic         l_press = 1'b0;
  logic         r_press = 1'b0;
  logic [N-1:0] leds;
  logic [1:0]   winner;
  logic [2:0]   l_score;
  logic [2:0]   r_score;
  logic         match_over;

  always #5 clk = ~clk;

  tow_playfield #(.N_LIGHTS(N), .HOLD_CYCLES(HC), .WIN_LIMIT(WL)) dut (
    .clk        (clk),
    .reset      (reset),
    .l_press    (l_press),
    .r_press    (r_press),
    .leds       (leds),
    .winner     (winner),
    .l_score    (l_score),
    .r_score    (r_score),
    .match_over (match_over)
  );

  typedef struct {
    logic [N-1:0] leds;
    logic [1:0]   winner;
    logic [2:0]   ls;
    logic [2:0]   rs;
    logic         mo;
  } exp_t;

  typedef struct {
    logic         l;
    logic         r;
    int           np;
    int           ni;
    logic [N-1:0] leds;
    logic [1:0]   win;
    logic [2:0]   ls;
    logic [2:0]   rs;
  } vec_t;

  exp_t sb[$];
  vec_t vt[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model: 0 play, 1 hold, 2 idle; hold counts cycles elapsed.
  int m_pos, m_state, m_el, m_win, m_ls, m_rs, m_mo;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = (N - 1) / 2; m_state = 0; m_el = 0;
    m_win = 0; m_ls = 0; m_rs = 0; m_mo = 0;
  endtask

  task automatic model_tick(input logic l, input logic r);
    case (m_state)
      0: begin
        if (l && !r) begin
          if (m_pos == N - 1) begin m_win = 1; m_ls++; m_state = 1; m_el = 0; end
          else m_pos++;
        end else if (r && !l) begin
          if (m_pos == 0) begin m_win = 2; m_rs++; m_state = 1; m_el = 0; end
          else m_pos--;
        end
      end
      1: begin
        m_el++;
        if (m_el == HC) begin
          if (m_ls == WL || m_rs == WL) begin m_state = 2; m_mo = 1; end
          else begin m_state = 0; m_win = 0; m_pos = (N - 1) / 2; end
        end
      end
      default: ;
    endcase
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.leds   = (m_state == 2) ? '0 : (N'(1) << m_pos);
    e.winner = 2'(m_win);
    e.ls     = 3'(m_ls);
    e.rs     = 3'(m_rs);
    e.mo     = m_mo[0];
    return e;
  endfunction

  // One clock: drive at negedge, predict, sample 1 time unit after posedge.
  task automatic step(input logic l, input logic r);
    exp_t e;
    @(negedge clk);
    l_press = l;
    r_press = r;
    model_tick(l, r);
    sb.push_back(model_exp());
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      check("sb_leds",   16'(leds),       16'(e.leds));
      check("sb_winner", 16'(winner),     16'(e.winner));
      check("sb_lscore", 16'(l_score),    16'(e.ls));
      check("sb_rscore", 16'(r_score),    16'(e.rs));
      check("sb_match",  16'(match_over), 16'(e.mo));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_leds"},   16'(leds),       16'h010);
    check({tag, "_winner"}, 16'(winner),     16'd0);
    check({tag, "_lscore"}, 16'(l_score),    16'd0);
    check({tag, "_rscore"}, 16'(r_score),    16'd0);
    check({tag, "_match"},  16'(match_over), 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Walk left to the end, win, hold, then cancel, then right win with presses in HOLD.
    vt.push_back('{1'b1, 1'b0, 1, 2, 9'h020, 2'b00, 3'd0, 3'd0});
    vt.push_back('{1'b1, 1'b0, 1, 2, 9'h040, 2'b00, 3'd0, 3'd0});
    vt.push_back('{1'b1, 1'b0, 1, 2, 9'h080, 2'b00, 3'd0, 3'd0});
    vt.push_back('{1'b1, 1'b0, 1, 2, 9'h100, 2'b00, 3'd0, 3'd0});
    vt.push_back('{1'b1, 1'b0, 1, 0, 9'h100, 2'b01, 3'd1, 3'd0});
    vt.push_back('{1'b0, 1'b0, 0, 7, 9'h100, 2'b01, 3'd1, 3'd0});
    vt.push_back('{1'b0, 1'b0, 0, 1, 9'h010, 2'b00, 3'd1, 3'd0});
    vt.push_back('{1'b1, 1'b1, 5, 0, 9'h010, 2'b00, 3'd1, 3'd0});
    vt.push_back('{1'b0, 1'b1, 1, 0, 9'h008, 2'b00, 3'd1, 3'd0});
    vt.push_back('{1'b0, 1'b1, 1, 0, 9'h004, 2'b00, 3'd1, 3'd0});
    vt.push_back('{1'b0, 1'b1, 1, 0, 9'h002, 2'b00, 3'd1, 3'd0});
    vt.push_back('{1'b0, 1'b1, 1, 0, 9'h001, 2'b00, 3'd1, 3'd0});
    vt.push_back('{1'b0, 1'b1, 1, 0, 9'h001, 2'b10, 3'd1, 3'd1});
    vt.push_back('{1'b0, 1'b1, 7, 0, 9'h001, 2'b10, 3'd1, 3'd1});
    vt.push_back('{1'b0, 1'b1, 1, 0, 9'h010, 2'b00, 3'd1, 3'd1});
    vt.push_back('{1'b0, 1'b1, 1, 0, 9'h008, 2'b00, 3'd1, 3'd1});

    // Power-on reset.
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("por");
    reset = 1'b1;
    model_reset();

    // Table-driven vectors.
    for (int i = 0; i < vt.size(); i++) begin
      for (int k = 0; k < vt[i].np; k++) step(vt[i].l, vt[i].r);
      for (int k = 0; k < vt[i].ni; k++) step(1'b0, 1'b0);
      check($sformatf("vec%0d_leds", i),   16'(leds),    16'(vt[i].leds));
      check($sformatf("vec%0d_winner", i), 16'(winner),  16'(vt[i].win));
      check($sformatf("vec%0d_lscore", i), 16'(l_score), 16'(vt[i].ls));
      check($sformatf("vec%0d_rscore", i), 16'(r_score), 16'(vt[i].rs));
    end

    // Right keeps pressing until the match ends.
    for (int k = 0; k < 600 && m_state != 2; k++) step(1'b0, 1'b1);
    check("end_match",  16'(match_over), 16'd1);
    check("end_rscore", 16'(r_score),    16'd7);
    check("end_lscore", 16'(l_score),    16'd1);
    check("end_winner", 16'(winner),     16'b10);
    check("end_leds",   16'(leds),       16'd0);

    // Presses in IDLE change nothing.
    for (int k = 0; k < 10; k++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("idle_rscore", 16'(r_score), 16'd7);
    check("idle_leds",   16'(leds),    16'd0);

    // Asynchronous reset while IDLE, with a press held during reset.
    @(negedge clk);
    l_press = 1'b0;
    r_press = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_values("rst_idle");
    @(negedge clk);
    l_press = 1'b1;
    @(posedge clk);
    #1 check("rst_press_ignored", 16'(leds), 16'h010);
    @(negedge clk);
    l_press = 1'b0;
    reset   = 1'b1;
    model_reset();

    // Left wins a round, then reset lands between edges mid-HOLD.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
    check("pre_hold_winner", 16'(winner), 16'b01);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_values("rst_hold");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    step(1'b0, 1'b1);
    check("post_rst_rpress", 16'(leds), 16'h008);

    step(1'b0, 1'b0);
    check("sb_drained", 16'(sb.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
